powlib_iparbiter: RTL and testbench



---
 rtl/powlib_iparbiter_pkg.sv | 27 ++
 rtl/powlib_iparbiter_rrpick.sv | 43 ++++
 rtl/powlib_iparbiter.sv | 141 ++++++++++++++
 tb/tb_powlib_iparbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/powlib_iparbiter_pkg.sv
// powlib_iparbiter_pkg
// Shared constants for the powlib IP-bus arbiter slice: bus field widths,
// op codes, arbiter lock-state encodings and the ceil-log2 width helper.
package powlib_iparbiter_pkg;

  // Bits per byte and width of the op field carried in each packed beat.
  localparam int POWLIB_BW  = 8;
  localparam int POWLIB_OPW = 4;

  // Op codes carried in the top POWLIB_OPW bits of a packed beat.
  localparam logic [POWLIB_OPW-1:0] POWLIB_OP_WRITE = 4'd0;
  localparam logic [POWLIB_OPW-1:0] POWLIB_OP_READ  = 4'd1;
  localparam logic [POWLIB_OPW-1:0] POWLIB_OP_SET   = 4'd2;
  localparam logic [POWLIB_OPW-1:0] POWLIB_OP_CLEAR = 4'd3;

  // Burst lock state encodings.
  typedef enum logic {
    POWLIB_IPARB_IDLE = 1'b0,
    POWLIB_IPARB_LOCK = 1'b1
  } iparb_state_e;

  // Index width needed to address v items; never less than one bit.
  function automatic int powlib_clogb2(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/powlib_iparbiter_rrpick.sv
// powlib_iprrpick
// Combinational round-robin picker. Scans req in order last+1, last+2, ...
// modulo N and reports the first set index.
// Ports:
//   req     in  N   request vector
//   last    in  SW  index granted most recently (lowest priority)
//   gnt_vld out 1   some request is set
//   gnt_idx out SW  chosen index (equals last when gnt_vld is 0)
module powlib_iprrpick
  import powlib_iparbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int SW = powlib_clogb2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] last,
  output logic          gnt_vld,
  output logic [SW-1:0] gnt_idx
);

  // Priority scan starting just after the last winner; explicit wrap so
  // N does not have to be a power of two.
  always_comb begin
    int pos;
    logic [SW-1:0] cand;
    gnt_vld = 1'b0;
    gnt_idx = last;
    pos     = 0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      pos  = int'(last) + k;
      pos  = (pos >= N) ? (pos - N) : pos;
      cand = SW'(pos);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end else begin
        gnt_vld = gnt_vld;
      end
    end
  end

endmodule

// File: rtl/powlib_iparbiter.sv
// powlib_iparbiter
// Round-robin arbiter sharing one powlib IP bus slave port between N
// requesters through a single-entry output register. rdsel tells a
// response router which requester sourced the current output beat.
// Optional feature macro: POWLIB_IPARBITER_BURST_EN keeps the grant on
// one requester for up to MAXB consecutive beats.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   wraddr     N*B_AW requester addresses, requester i at [i*B_AW+:B_AW]
//   wrdata     N*B_WW packed requester beats, requester i at [i*B_WW+:B_WW]
//   wrvld      N      per-requester valid
//   wrrdy      N      per-requester ready, one-hot or zero
//   rdaddr     B_AW   granted address
//   rddata     B_WW   granted packed beat
//   rdsel      SW     requester index of the current output beat
//   rdvld      1      output valid
//   rdrdy      1      downstream ready
module powlib_iparbiter
  import powlib_iparbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int B_BPD = 4,
  parameter int B_AW  = POWLIB_BW * B_BPD,
  parameter int MAXB  = 4,
  localparam int B_WW = POWLIB_OPW + B_BPD + POWLIB_BW * B_BPD,
  localparam int SW   = powlib_clogb2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*B_AW-1:0] wraddr,
  input  logic [N*B_WW-1:0] wrdata,
  input  logic [N-1:0]      wrvld,
  output logic [N-1:0]      wrrdy,
  output logic [B_AW-1:0]   rdaddr,
  output logic [B_WW-1:0]   rddata,
  output logic [SW-1:0]     rdsel,
  output logic              rdvld,
  input  logic              rdrdy
);

  logic          open;
  logic          hold;
  logic          pick_vld;
  logic [SW-1:0] pick_idx;
  logic          gnt_vld;
  logic [SW-1:0] gnt_idx;
  logic [SW-1:0] last;

  // The output register can take a beat when it is empty or being drained.
  assign open = ~rdvld | rdrdy;

  powlib_iprrpick #(.N(N)) u_pick (
    .req     (wrvld),
    .last    (last),
    .gnt_vld (pick_vld),
    .gnt_idx (pick_idx)
  );

`ifdef POWLIB_IPARBITER_BURST_EN
  localparam int CW = powlib_clogb2(MAXB + 1);

  iparb_state_e  state;
  logic [CW-1:0] count;

  // While locked and the owner is still valid, the picker is bypassed.
  assign hold = (state == POWLIB_IPARB_LOCK) && wrvld[last];

  // Burst lock FSM: enter on any fresh grant, leave after MAXB beats or as
  // soon as the owner drops valid while the output could accept a beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= POWLIB_IPARB_IDLE;
      count <= '0;
    end else if (hold && gnt_vld) begin
      if (count == CW'(MAXB - 1)) begin
        state <= POWLIB_IPARB_IDLE;
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end else if (gnt_vld) begin
      // Fresh arbitration win (from IDLE or a same-cycle release).
      state <= (MAXB > 1) ? POWLIB_IPARB_LOCK : POWLIB_IPARB_IDLE;
      count <= CW'(1);
    end else if ((state == POWLIB_IPARB_LOCK) && open && !wrvld[last]) begin
      state <= POWLIB_IPARB_IDLE;
      count <= '0;
    end
  end
`else
  assign hold = 1'b0;
`endif

  // Grant selection; nothing is granted while reset is asserted so that no
  // requester sees an acknowledge for a beat that reset discards.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = pick_idx;
    if (open && !rst) begin
      if (hold) begin
        gnt_vld = 1'b1;
        gnt_idx = last;
      end else begin
        gnt_vld = pick_vld;
        gnt_idx = pick_idx;
      end
    end else begin
      gnt_vld = 1'b0;
    end
  end

  // One-hot ready toward the granted requester only.
  always_comb begin
    wrrdy = '0;
    if (gnt_vld) begin
      wrrdy[gnt_idx] = 1'b1;
    end else begin
      wrrdy = '0;
    end
  end

  // Output register and last-granted pointer; load and drain may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdvld  <= 1'b0;
      rdsel  <= '0;
      rdaddr <= '0;
      rddata <= '0;
      last   <= SW'(N - 1);
    end else if (gnt_vld) begin
      rdvld  <= 1'b1;
      rdsel  <= gnt_idx;
      rdaddr <= wraddr[gnt_idx*B_AW +: B_AW];
      rddata <= wrdata[gnt_idx*B_WW +: B_WW];
      last   <= gnt_idx;
    end else if (open) begin
      rdvld  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_powlib_iparbiter.sv
// tb_powlib_iparbiter
// Table-driven check of the round-robin arbiter with N=4, MAXB=3, plus
// hand-written sequences for reset state and reset during backpressure.
module tb_powlib_iparbiter;

  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int WW   = 40;
  localparam int SW   = 2;
  localparam int MAXB = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*AW-1:0] wraddr;
  logic [N*WW-1:0] wrdata;
  logic [N-1:0]    wrvld;
  logic [N-1:0]    wrrdy;
  logic [AW-1:0]   rdaddr;
  logic [WW-1:0]   rddata;
  logic [SW-1:0]   rdsel;
  logic            rdvld;
  logic            rdrdy;

  int total_cnt = 0;
  int pass_cnt  = 0;

  typedef struct {
    logic [N-1:0]  vld;
    logic          rdy;
    logic [N-1:0]  exp_rdy;
    logic          exp_vld;
    logic [SW-1:0] exp_sel;
  } vec_t;

  vec_t vecs[$];

  powlib_iparbiter #(.N(N), .B_BPD(4), .B_AW(AW), .MAXB(MAXB)) dut (
    .clk    (clk),
    .rst    (rst),
    .wraddr (wraddr),
    .wrdata (wrdata),
    .wrvld  (wrvld),
    .wrrdy  (wrrdy),
    .rdaddr (rdaddr),
    .rddata (rddata),
    .rdsel  (rdsel),
    .rdvld  (rdvld),
    .rdrdy  (rdrdy)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] addr_of(input int i);
    return 32'hA000_0000 + 32'(i) * 32'h0000_0110;
  endfunction

  function automatic logic [WW-1:0] data_of(input int i);
    return 40'h5A_0000_0000 + 40'(i) * 40'h0000_0103;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic add(input logic [N-1:0] v, input logic r, input logic [N-1:0] er,
                     input logic ev, input logic [SW-1:0] es);
    vec_t t;
    t.vld = v; t.rdy = r; t.exp_rdy = er; t.exp_vld = ev; t.exp_sel = es;
    vecs.push_back(t);
  endtask

  task automatic check_out(input string nm, input logic ev, input logic [SW-1:0] es);
    chk({nm, ".rdvld"}, 64'(rdvld), 64'(ev));
    chk({nm, ".rdsel"}, 64'(rdsel), 64'(es));
    if (ev) begin
      chk({nm, ".rdaddr"}, 64'(rdaddr), 64'(addr_of(int'(es))));
      chk({nm, ".rddata"}, 64'(rddata), 64'(data_of(int'(es))));
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      wraddr[i*AW +: AW] = addr_of(i);
      wrdata[i*WW +: WW] = data_of(i);
    end

`ifdef POWLIB_IPARBITER_BURST_EN
    // Burst lock, MAXB=3: requesters 1 and 2 continuously valid.
    add(4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1);
    add(4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1);
    add(4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1);
    add(4'b0110, 1'b1, 4'b0100, 1'b1, 2'd2);
    add(4'b0110, 1'b1, 4'b0100, 1'b1, 2'd2);
    add(4'b0110, 1'b1, 4'b0100, 1'b1, 2'd2);
    add(4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1);
    add(4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1);
    // Requester 1 drops after two beats: lock releases to 2 at once.
    add(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2);
    add(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2);
    add(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2);
`else
    // Requesters 0 and 2 after reset: 0 first, then 2.
    add(4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0);
    add(4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2);
    add(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2);
    // Fairness: all four continuously valid.
    add(4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3);
    add(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0);
    add(4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1);
    add(4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2);
    add(4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3);
    // Backpressure for 5 cycles, then the next beat follows immediately.
    for (int i = 0; i < 5; i++) add(4'b1111, 1'b0, 4'b0000, 1'b1, 2'd3);
    add(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0);
    add(4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0);
    add(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0);
`endif

    // Reset state.
    rst = 1'b1; wrvld = '0; rdrdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.rdvld", 64'(rdvld), 64'd0);
    chk("rst.rdsel", 64'(rdsel), 64'd0);
    chk("rst.rdaddr", 64'(rdaddr), 64'd0);
    chk("rst.rddata", 64'(rddata), 64'd0);
    chk("rst.wrrdy", 64'(wrrdy), 64'd0);
    rst = 1'b0;

    // Table: inputs for one cycle, ready checked before the edge and the
    // output register checked just after it.
    for (int i = 0; i < vecs.size(); i++) begin
      wrvld = vecs[i].vld;
      rdrdy = vecs[i].rdy;
      #2;
      chk($sformatf("vec%0d.wrrdy", i), 64'(wrrdy), 64'(vecs[i].exp_rdy));
      @(posedge clk); #1;
      check_out($sformatf("vec%0d", i), vecs[i].exp_vld, vecs[i].exp_sel);
    end

    // Reset while a beat is held under backpressure.
    wrvld = 4'b0100; rdrdy = 1'b0;
    #2;
    chk("mid.load.wrrdy", 64'(wrrdy), 64'b0100);
    @(posedge clk); #1;
    check_out("mid.load", 1'b1, 2'd2);
    wrvld = 4'b1111;
    #2;
    chk("mid.held.wrrdy", 64'(wrrdy), 64'd0);
    rst = 1'b1;
    #1;
    chk("mid.inrst.wrrdy", 64'(wrrdy), 64'd0);
    @(posedge clk); #1;
    chk("mid.after.rdvld", 64'(rdvld), 64'd0);
    chk("mid.after.wrrdy", 64'(wrrdy), 64'd0);
    rst = 1'b0; rdrdy = 1'b1;
    #2;
    chk("mid.first.wrrdy", 64'(wrrdy), 64'b0001);
    @(posedge clk); #1;
    check_out("mid.first", 1'b1, 2'd0);

    wrvld = '0;
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
